// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared types and constants for the framebuffer read arbiter
//   req_id_t    - requester identifier stored per outstanding read
//   arb_state_t - request-path hold state (free, or held on one port)
package fb_arb_pkg;
   typedef logic [0:0] req_id_t;
   localparam int NUM_PORTS = 2;
   localparam req_id_t PORT_DISPLAY = 1'b0;
   localparam req_id_t PORT_CPU = 1'b1;
   typedef enum logic [1:0] {ARB_FREE, ARB_HOLD_DISP, ARB_HOLD_CPU} arb_state_t;
endpackage

// File: rtl/id_fifo.sv
// id_fifo: synchronous FIFO of requester IDs, one entry per outstanding read
//   clk, reset    - clock, synchronous active-high reset (empties the FIFO)
//   push, push_id - enqueue an ID (ignored when full)
//   pop, pop_id   - dequeue the head ID (ignored when empty); pop_id shows the head
//   full, empty   - occupancy flags
//   count         - number of stored IDs
// Simultaneous push and pop leave count unchanged and keep order.
module id_fifo
   import fb_arb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  req_id_t                  push_id,
   input  logic                     pop,
   output req_id_t                  pop_id,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   req_id_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & !full;
   assign do_pop  = pop & !empty;
   assign pop_id  = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_id;
   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/fb_read_arbiter.sv
// fb_read_arbiter: shares one 8-bit Avalon-MM read master between display (s0) and CPU (s1)
//   clk, reset                 - clock, synchronous active-high reset
//   avs_s0_* / avs_s1_*        - requester slave ports (read, address, waitrequest, readdata, readdatavalid)
//   avm_master_*               - shared pipelined read master
//   pending_count              - accepted reads still awaiting data
//   err_unexpected             - sticky flag: data beat arrived with no outstanding read
// Build option DISPLAY_PRIORITY_EN: display port wins every tie instead of round-robin.
module fb_read_arbiter
   import fb_arb_pkg::*;
#(
   parameter int MAX_PENDING = 8,
   parameter int ADDR_W      = 24
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           avs_s0_read,
   input  logic [ADDR_W-1:0]              avs_s0_address,
   output logic                           avs_s0_waitrequest,
   output logic [7:0]                     avs_s0_readdata,
   output logic                           avs_s0_readdatavalid,
   input  logic                           avs_s1_read,
   input  logic [ADDR_W-1:0]              avs_s1_address,
   output logic                           avs_s1_waitrequest,
   output logic [7:0]                     avs_s1_readdata,
   output logic                           avs_s1_readdatavalid,
   output logic                           avm_master_read,
   output logic [ADDR_W-1:0]              avm_master_address,
   input  logic                           avm_master_waitrequest,
   input  logic [7:0]                     avm_master_readdata,
   input  logic                           avm_master_readdatavalid,
   output logic [$clog2(MAX_PENDING):0]   pending_count,
   output logic                           err_unexpected
);
   arb_state_t state_q, state_d;
   logic [NUM_PORTS-1:0] req;
   req_id_t gnt_id, tie_id, pop_id;
   logic full, empty, accept, pop;
   assign req = {avs_s1_read, avs_s0_read};
`ifdef DISPLAY_PRIORITY_EN
   assign tie_id = PORT_DISPLAY;
`else
   req_id_t last_grant;
   assign tie_id = ~last_grant;
   always_ff @(posedge clk) begin
      if (reset) last_grant <= PORT_CPU;
      else if (accept) last_grant <= gnt_id;
   end
`endif
   // A stalled request holds the grant on its port until the master accepts it
   always_comb begin
      gnt_id = state_q == ARB_HOLD_CPU ? PORT_CPU :
               state_q == ARB_HOLD_DISP ? PORT_DISPLAY :
               &req ? tie_id : req[PORT_CPU] ? PORT_CPU : PORT_DISPLAY;
      avm_master_read = req[gnt_id] & !full;
      state_d = !(avm_master_read & avm_master_waitrequest) ? ARB_FREE :
                gnt_id == PORT_CPU ? ARB_HOLD_CPU : ARB_HOLD_DISP;
   end
   always_ff @(posedge clk) begin
      if (reset) state_q <= ARB_FREE;
      else state_q <= state_d;
   end
   assign avm_master_address = gnt_id == PORT_CPU ? avs_s1_address : avs_s0_address;
   assign accept = avm_master_read & !avm_master_waitrequest;
   assign avs_s0_waitrequest = avs_s0_read &
      !(gnt_id == PORT_DISPLAY & !full & !avm_master_waitrequest);
   assign avs_s1_waitrequest = avs_s1_read &
      !(gnt_id == PORT_CPU & !full & !avm_master_waitrequest);
   // Full is judged on the pre-pop count, so a same-cycle return never frees a slot early
   assign pop = avm_master_readdatavalid & !empty;
   id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (accept),
      .push_id (gnt_id),
      .pop     (pop),
      .pop_id  (pop_id),
      .full    (full),
      .empty   (empty),
      .count   (pending_count)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         avs_s0_readdatavalid <= 1'b0;
         avs_s1_readdatavalid <= 1'b0;
         avs_s0_readdata      <= '0;
         avs_s1_readdata      <= '0;
         err_unexpected       <= 1'b0;
      end else begin
         avs_s0_readdatavalid <= pop & pop_id == PORT_DISPLAY;
         avs_s1_readdatavalid <= pop & pop_id == PORT_CPU;
         if (pop & pop_id == PORT_DISPLAY) avs_s0_readdata <= avm_master_readdata;
         if (pop & pop_id == PORT_CPU) avs_s1_readdata <= avm_master_readdata;
         err_unexpected <= err_unexpected | (avm_master_readdatavalid & empty);
      end
   end
endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb_fb_read_arbiter: randomized bench for fb_read_arbiter against a queue-based reference model
module tb_fb_read_arbiter;
   localparam int MAXP = 8;
   localparam int AW = 24;
`ifdef DISPLAY_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   logic s0_read, s1_read, s0_wait, s1_wait, s0_rdv, s1_rdv;
   logic [AW-1:0] s0_addr, s1_addr, m_addr;
   logic [7:0] s0_data, s1_data, m_data;
   logic m_read, m_wait, m_rdv, err;
   logic [3:0] pend;
   fb_read_arbiter #(.MAX_PENDING(MAXP), .ADDR_W(AW)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .avs_s0_read              (s0_read),
      .avs_s0_address           (s0_addr),
      .avs_s0_waitrequest       (s0_wait),
      .avs_s0_readdata          (s0_data),
      .avs_s0_readdatavalid     (s0_rdv),
      .avs_s1_read              (s1_read),
      .avs_s1_address           (s1_addr),
      .avs_s1_waitrequest       (s1_wait),
      .avs_s1_readdata          (s1_data),
      .avs_s1_readdatavalid     (s1_rdv),
      .avm_master_read          (m_read),
      .avm_master_address       (m_addr),
      .avm_master_waitrequest   (m_wait),
      .avm_master_readdata      (m_data),
      .avm_master_readdatavalid (m_rdv),
      .pending_count            (pend),
      .err_unexpected           (err)
   );
   int n_err = 0;
   int n_chk = 0;
   // reference model state
   int q[$];
   int last_g = 1;
   int hold = -1;
   bit e_rdv[2];
   logic [7:0] e_data[2];
   bit e_err;
   bit accepted[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, then advance the model at the rising edge
   task automatic cyc(input bit do_chk);
      int g, id;
      bit full, e_mread;
      bit req[2];
      bit e_wait[2];
      @(negedge clk);
      req[0] = s0_read;
      req[1] = s1_read;
      full = q.size() == MAXP;
      if (hold >= 0) g = hold;
      else if (req[0] && req[1]) g = PRIO ? 0 : 1 - last_g;
      else g = req[1] ? 1 : 0;
      e_mread = req[g] && !full;
      for (int n = 0; n < 2; n++) e_wait[n] = req[n] && !(g == n && !full && !m_wait);
      if (do_chk) begin
         chk("m_read", m_read, e_mread);
         if (e_mread) chk("m_addr", m_addr, g ? s1_addr : s0_addr);
         chk("s0_wait", s0_wait, e_wait[0]);
         chk("s1_wait", s1_wait, e_wait[1]);
         chk("s0_rdv", s0_rdv, e_rdv[0]);
         chk("s1_rdv", s1_rdv, e_rdv[1]);
         chk("s0_data", s0_data, e_data[0]);
         chk("s1_data", s1_data, e_data[1]);
         chk("pending", pend, q.size());
         chk("err", err, e_err);
      end
      for (int n = 0; n < 2; n++) accepted[n] = req[n] && !e_wait[n];
      @(posedge clk);
      if (reset) begin
         q.delete();
         last_g = 1;
         hold = -1;
         e_rdv = '{0, 0};
         e_data = '{8'h00, 8'h00};
         e_err = 0;
      end else begin
         e_rdv = '{0, 0};
         if (m_rdv) begin
            if (q.size() > 0) begin
               id = q.pop_front();
               e_rdv[id] = 1;
               e_data[id] = m_data;
            end else e_err = 1;
         end
         if (e_mread && !m_wait) begin
            q.push_back(g);
            last_g = g;
         end
         hold = (e_mread && m_wait) ? g : -1;
      end
      #1;
   endtask

   task automatic drain();
      s0_read = 0;
      s1_read = 0;
      m_wait = 0;
      for (int i = 0; i < 40 && q.size() > 0; i++) begin
         m_rdv = 1;
         m_data = 8'($urandom);
         cyc(1);
      end
      m_rdv = 0;
      cyc(1);
   endtask

   initial begin
      s0_read = 0; s1_read = 0; s0_addr = '0; s1_addr = '0;
      m_wait = 0; m_rdv = 0; m_data = '0;
      reset = 1;
      cyc(0);
      cyc(1);
      reset = 0;
      cyc(1);
      // single display read
      s0_read = 1;
      s0_addr = 24'h000010;
      #1;
      chk("t1_addr", m_addr, 24'h000010);
      chk("t1_wait", s0_wait, 0);
      cyc(1);
      s0_read = 0;
      cyc(1);
      cyc(1);
      m_rdv = 1;
      m_data = 8'hA5;
      cyc(1);
      m_rdv = 0;
      chk("t1_rdv0", s0_rdv, 1);
      chk("t1_data0", s0_data, 8'hA5);
      chk("t1_rdv1", s1_rdv, 0);
      cyc(1);
      // randomized traffic; requesters keep read/address stable while stalled
      repeat (3000) begin
         if (!(s0_read && !accepted[0])) begin
            s0_read = $urandom_range(0, 99) < 60;
            s0_addr = AW'($urandom);
         end
         if (!(s1_read && !accepted[1])) begin
            s1_read = $urandom_range(0, 99) < 60;
            s1_addr = AW'($urandom);
         end
         m_wait = $urandom_range(0, 99) < 30;
         m_rdv = q.size() > 0 && $urandom_range(0, 1) == 1;
         m_data = 8'($urandom);
         cyc(1);
      end
      drain();
      // fill to capacity
      s0_read = 1; s0_addr = 24'h000100;
      s1_read = 1; s1_addr = 24'h000200;
      repeat (MAXP) begin
         cyc(1);
         if (accepted[0]) s0_addr++;
         if (accepted[1]) s1_addr++;
      end
      #1;
      chk("fill_pend", pend, 8);
      chk("fill_w0", s0_wait, 1);
      chk("fill_w1", s1_wait, 1);
      chk("fill_mread", m_read, 0);
      m_rdv = 1;
      m_data = 8'h5A;
      cyc(1);
      m_rdv = 0;
      chk("pop_pend", pend, 7);
      cyc(1);
      chk("refill_pend", pend, 8);
      drain();
      // reset with reads outstanding, then stray beats
      s0_read = 1;
      repeat (3) begin
         cyc(1);
         s0_addr++;
      end
      s0_read = 0;
      chk("pre_rst_pend", pend, 3);
      reset = 1;
      cyc(1);
      reset = 0;
      m_rdv = 1;
      m_data = 8'hEE;
      repeat (3) cyc(1);
      m_rdv = 0;
      chk("stray_err", err, 1);
      chk("stray_pend", pend, 0);
      chk("stray_rdv", s0_rdv | s1_rdv, 0);
      cyc(1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
Shares the single 8-bit framebuffer Avalon-MM read master between two requesters: port 0 (display scanout via the palette expander) and port 1 (CPU/blitter readback). Pipelined reads with up to MAX_PENDING outstanding transactions. A requester-ID FIFO routes each readdatavalid beat back to the port that issued it. Sits between the palette block's memory master and the SDRAM/on-chip framebuffer interconnect.

Parameters:
MAX_PENDING, 8, max outstanding accepted reads; power of two, 2..32
ADDR_W, 24, address width on all ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
avs_s0_read  in  1  port 0 read request
avs_s0_address  in  ADDR_W  port 0 byte address
avs_s0_waitrequest  out  1  port 0 stall
avs_s0_readdata  out  8  port 0 returned byte
avs_s0_readdatavalid  out  1  port 0 data strobe
avs_s1_read / avs_s1_address / avs_s1_waitrequest / avs_s1_readdata / avs_s1_readdatavalid  as port 0, for port 1
avm_master_read  out  1  shared read request
avm_master_address  out  ADDR_W  shared address
avm_master_waitrequest  in  1  downstream stall
avm_master_readdata  in  8  downstream data
avm_master_readdatavalid  in  1  downstream data strobe
pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads
err_unexpected  out  1  sticky: readdatavalid with empty ID FIFO

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset: all readdata 0, readdatavalid 0, pending_count 0, err_unexpected 0, FIFO emptied, lock cleared, last_grant=1 (port 0 wins first tie).
- Request path combinational: avm_master_read/address muxed from granted port; avm_master_read=0 when nothing granted or FIFO full.
- Grant: if lock set, keep locked port. Else one requester -> it; both -> port not equal last_grant (round-robin).
- Lock: set when avm_master_read=1 and avm_master_waitrequest=1 (request must stay stable); cleared on acceptance. Requester dropping read while locked is a protocol violation; lock clears next cycle, no transfer counted.
- Acceptance = avm_master_read & !avm_master_waitrequest: push granted ID, last_grant<=ID.
- avs_sN_waitrequest = avs_sN_read & !(granted N & !full & !avm_master_waitrequest). Non-granted requester always stalled.
- Full: pending==MAX_PENDING blocks acceptance even if a pop occurs same cycle.
- Response path registered, latency 1: on avm_master_readdatavalid with FIFO non-empty, pop head ID; next cycle avs_s<ID>_readdatavalid=1, avs_s<ID>_readdata=beat; other port's strobe 0; readdata holds last value otherwise.
- Push+pop same cycle: pending unchanged, order preserved.
- readdatavalid with empty FIFO: beat dropped, err_unexpected<=1 until reset (covers beats in flight across a reset).
- Responses return strictly in acceptance order; no reordering.

Optional Feature:
DISPLAY_PRIORITY_EN
- Defined: port 0 always wins a tie (fixed priority, protects scanout); lock rules unchanged; last_grant unused.
- Undefined: round-robin as above.

Decomposition:
- Package fb_arb_pkg: typedef logic [0:0] req_id_t; constants NUM_PORTS=2, PORT_DISPLAY=0, PORT_CPU=1.
- Sub-module id_fifo: synchronous FIFO of req_id_t, depth MAX_PENDING, push/pop/full/empty/count, simultaneous push+pop supported; instantiated once.

Test Plan:
- Port 0 reads 0x000010, waitrequest low, data 0xA5 returned 3 cycles later -> s0_readdatavalid one cycle after master strobe, readdata 0xA5; s1 strobe stays 0.
- Both ports request continuously (s0 0x100.., s1 0x200..) -> master addresses alternate 0x100,0x200,0x101,0x201; with DISPLAY_PRIORITY_EN all s0 first, s1 stalled.
- Port 0 granted, master waitrequest held 4 cycles while s1 requests -> address stays 0x100 all 4 cycles, s1 stalled, then s1 granted.
- Issue 8 reads with no returns (MAX_PENDING=8) -> pending_count=8, both waitrequests high; one return -> pending 7, next accept allowed following cycle.
- Interleaved IDs s0,s1,s1,s0 with data 0x11,0x22,0x33,0x44 -> s0 gets 0x11,0x44; s1 gets 0x22,0x33 in order.
- Reset asserted with 3 pending, then 3 stray readdatavalid -> no slave strobes, err_unexpected=1, pending_count=0.
